// File: rtl/kbd_fifo_ctrl.sv
// Keyboard register controller: buffered key events, typematic repeat, status/data registers and two interrupts.
// Register reads return data one cycle after the strobe edge; key pushes into a full FIFO are dropped and flagged.

// Generic FIFO with peek at head; caller qualifies push/pop against full/empty.
// Zero-latency head view; no internal backpressure, the caller owns the full/empty policy.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
endmodule

// Top: bus register pair, FIFO push/pop arbitration, interrupt arming and the auto-repeat machine.
// Read data valid one cycle after the strobe edge; ack is combinational; full-FIFO pushes drop and set ovf.
module kbd_fifo_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BASE_ADDR  = 16'o177660,
    parameter int          REP_DELAY  = 500,
    parameter int          REP_RATE   = 100,
    parameter bit          REP_EN     = 1'b1
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [15:0]                   bus_din,
    output logic [15:0]                   bus_dout,
    input  logic [15:0]                   bus_addr,
    input  logic                          bus_sync,
    input  logic                          bus_we,
    input  logic                          bus_stb,
    output logic                          bus_ack,
    output logic                          virq_req60,
    input  logic                          virq_ack60,
    output logic                          virq_req274,
    input  logic                          virq_ack274,
    input  logic                          key_strobe,
    input  logic [6:0]                    key_code,
    input  logic                          key_ar2,
    input  logic                          key_held,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int          LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd2;
    localparam int          CMAX      = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int          CW        = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rep_state_t;

    logic        sel_s;
    logic        sel_d;
    logic        sel;
    logic        stb_q;
    logic        fire;
    logic        rd_s;
    logic        wr_s;
    logic        rd_d;
    logic [15:0] data_o;
    logic [15:0] status_word;
    logic        irq_dis;
    logic        ovf;
    logic        irq_arm;
    logic [6:0]  hold;
    logic        ack60_q;
    logic        ack274_q;
    logic [7:0]  head;
    logic        empty;
    logic        full;
    logic        key_push;
    logic        rep_push;
    logic [7:0]  rep_ent;
    logic        push_req;
    logic [7:0]  push_dat;
    logic        pop_ok;
    logic        push_ok;
    logic        drop;
    logic        unused_bits;

    assign sel_s   = bus_sync && (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign sel_d   = bus_sync && (bus_addr[15:1] == DATA_ADDR[15:1]) && !bus_we;
    assign sel     = sel_s || sel_d;
    assign bus_ack = bus_stb && sel;
    assign bus_dout = sel ? data_o : 16'd0;

    // Actions fire once per strobe, on its rising edge while selected.
    assign fire = bus_stb && sel && !stb_q;
    assign rd_s = fire && sel_s && !bus_we;
    assign wr_s = fire && sel_s && bus_we;
    assign rd_d = fire && sel_d;

    assign status_word = {1'b0, ovf, 6'b0, !empty, irq_dis, 6'b0};

    assign key_push = key_strobe && (key_code != 7'd0);
    assign push_req = key_push || rep_push;
    assign push_dat = key_push ? {key_ar2, key_code} : rep_ent;
    assign pop_ok   = rd_d && !empty;
    assign push_ok  = push_req && (!full || pop_ok);
    assign drop     = push_req && full && !pop_ok;

    assign unused_bits = ^{bus_din[15], bus_din[13:7], bus_din[5:0], bus_addr[0], tick, key_held};

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (push_dat),
        .dout  (head),
        .level (fifo_level),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stb_q       <= 1'b0;
            data_o      <= 16'd0;
            irq_dis     <= 1'b1;
            ovf         <= 1'b0;
            hold        <= 7'd0;
            irq_arm     <= 1'b0;
            ack60_q     <= 1'b0;
            ack274_q    <= 1'b0;
            virq_req60  <= 1'b0;
            virq_req274 <= 1'b0;
        end else begin
            stb_q    <= bus_stb && sel;
            ack60_q  <= virq_ack60;
            ack274_q <= virq_ack274;
            irq_arm  <= (push_ok && empty) ||
                        (pop_ok && ((fifo_level != LW'(1)) || push_ok));

            if (rd_s) begin
                data_o <= status_word;
            end
            if (rd_d) begin
                data_o <= {9'b0, empty ? hold : head[6:0]};
            end
            if (pop_ok) begin
                hold <= head[6:0];
            end

            if (wr_s) begin
                irq_dis <= bus_din[6];
                if (bus_din[14]) begin
                    ovf <= 1'b0;
                end
            end
            if (drop) begin
                ovf <= 1'b1;
            end

            if (virq_ack60 && !ack60_q) begin
                virq_req60 <= 1'b0;
            end
            if (virq_ack274 && !ack274_q) begin
                virq_req274 <= 1'b0;
            end
            // The head entry at raise time picks the vector.
            if (irq_arm && !irq_dis && !empty) begin
                if (head[7]) begin
                    virq_req274 <= 1'b1;
                end else begin
                    virq_req60 <= 1'b1;
                end
            end
            if (pop_ok) begin
                virq_req60  <= 1'b0;
                virq_req274 <= 1'b0;
            end
        end
    end

    generate
        if (REP_EN) begin : g_rep
            localparam logic [CW-1:0] CNT_DELAY = CW'(REP_DELAY);
            localparam logic [CW-1:0] CNT_RATE  = CW'(REP_RATE);
            localparam logic [CW-1:0] CNT_ONE   = CW'(1);

            rep_state_t    state;
            logic [CW-1:0] cnt;
            logic [7:0]    ent;
            logic          expire;

            assign expire   = (state != S_IDLE) && key_held && tick && (cnt == CNT_ONE);
            // Repeats only refill an empty FIFO, and a fresh key press in the same cycle wins.
            assign rep_push = expire && !key_push && empty;
            assign rep_ent  = ent;

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    ent   <= 8'd0;
                end else if (key_push) begin
                    ent   <= {key_ar2, key_code};
                    cnt   <= CNT_DELAY;
                    state <= S_DELAY;
                end else if (state != S_IDLE) begin
                    if (!key_held) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (cnt == CNT_ONE) begin
                            cnt   <= CNT_RATE;
                            state <= S_REPEAT;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                end
            end
        end else begin : g_norep
            assign rep_push = 1'b0;
            assign rep_ent  = 8'd0;
        end
    endgenerate
endmodule
